// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
//  Module      : rr_mux_arbiter_pkg
//  Description : Shared state encoding and helper function for the
//                round-robin mux arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

    // Arbiter state encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_GRANT = c_ST_GRANT
    } state_e;

    // Ceiling log2; used to size the burst counter
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : rr_mux_arbiter_pkg

`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner search. Starting at i_ptr
//                and wrapping from N-1 to 0, returns the first requesting
//                index and a flag that any request is present.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int unsigned K = 4
) (
    input  logic [2**K-1:0] i_req,
    input  logic [K-1:0]    i_ptr,
    output logic [K-1:0]    o_winner,
    output logic            o_any_req
);

    localparam int unsigned c_N = 2**K;

    // Scan from the farthest offset down so the nearest requester overwrites last
    always_comb begin
        logic [K-1:0] w_idx;
        w_idx     = '0;
        o_winner  = '0;
        o_any_req = 1'b0;
        for (int i = c_N - 1; i >= 0; i--) begin
            w_idx = i_ptr + K'(i);
            if (i_req[w_idx]) begin
                o_winner  = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
//  Module      : rr_mux_arbiter
//  Description : Round-robin arbiter sharing one single-bit valid/ready
//                channel among 2**K requesters, with a per-grant burst cap
//                and one idle bubble between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned K         = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**K-1:0] req,
    input  logic [2**K-1:0] data_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_data,
    output logic [2**K-1:0] grant,
    output logic [K-1:0]    sel,
    output logic            busy
);

    localparam int unsigned         c_BURST_W    = clog2(MAX_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST - 1);

    state_e               r_state_q, w_state_d;
    logic [K-1:0]         r_sel_q,   w_sel_d;
    logic [K-1:0]         r_ptr_q,   w_ptr_d;
    logic [c_BURST_W-1:0] r_burst_q, w_burst_d;

    logic [K-1:0] w_winner;
    logic         w_any_req;
    logic         w_busy;
    logic         w_valid;
    logic         w_xfer;

    rr_pick #(
        .K (K)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr_q),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Channel outputs are decoded from the registered owner only
    always_comb begin
        w_busy  = (r_state_q == ST_GRANT);
        w_valid = w_busy & req[r_sel_q];
        w_xfer  = w_valid & out_ready;
        grant   = '0;
        if (w_busy) begin
            grant[r_sel_q] = 1'b1;
        end
    end

    assign busy      = w_busy;
    assign out_valid = w_valid;
    assign out_data  = w_valid & data_in[r_sel_q];
    assign sel       = r_sel_q;

    // Next-state: pick a winner in IDLE, count transfers and release in GRANT
    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_ptr_d   = r_ptr_q;
        w_burst_d = r_burst_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_d = ST_GRANT;
                    w_sel_d   = w_winner;
                    w_burst_d = '0;
                end
            end
            ST_GRANT: begin
                if (!req[r_sel_q]) begin
                    // Owner withdrew: no transfer this cycle, hand priority onward
                    w_state_d = ST_IDLE;
                    w_ptr_d   = r_sel_q + K'(1);
                    w_burst_d = '0;
                end else if (w_xfer) begin
                    if (r_burst_q == c_BURST_LAST) begin
                        // Final transfer of the burst completes, then release
                        w_state_d = ST_IDLE;
                        w_ptr_d   = r_sel_q + K'(1);
                        w_burst_d = '0;
                    end else begin
                        w_burst_d = r_burst_q + c_BURST_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_sel_q   <= '0;
            r_ptr_q   <= '0;
            r_burst_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_ptr_q   <= w_ptr_d;
            r_burst_q <= w_burst_d;
        end
    end

endmodule : rr_mux_arbiter

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
//  Module      : tb_rr_mux_arbiter
//  Description : Self-checking bench for rr_mux_arbiter (K=2, MAX_BURST=3)
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

    localparam int unsigned K         = 2;
    localparam int unsigned N         = 2**K;
    localparam int unsigned MAX_BURST = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] data_in;
    logic         out_ready;
    logic         out_valid;
    logic         out_data;
    logic [N-1:0] grant;
    logic [K-1:0] sel;
    logic         busy;

    int n_checks;
    int n_pass;

    // Reference model: who owns the channel, how many transfers done, next priority
    bit m_owned;
    int m_owner;
    int m_done;
    int m_ptr;
    int m_sel;

    // Grant-start capture for the fairness sequence
    bit capture_en;
    bit prev_busy;
    int starts[$];

    rr_mux_arbiter #(
        .K         (K),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs === exp_val) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_val, $time);
        end
    endtask

    function automatic void model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_done  = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endfunction

    // Advance the model by one clock edge given the inputs seen in that cycle
    function automatic void model_step(input logic r, input logic [N-1:0] rq, input logic rdy);
        if (r) begin
            model_reset();
        end else if (!m_owned) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (m_ptr + i) % N;
                if (rq[idx]) begin
                    m_owned = 1'b1;
                    m_owner = idx;
                    m_sel   = idx;
                    m_done  = 0;
                    break;
                end
            end
        end else if (!rq[m_owner]) begin
            m_owned = 1'b0;
            m_ptr   = (m_owner + 1) % N;
        end else if (rdy) begin
            m_done++;
            if (m_done == MAX_BURST) begin
                m_owned = 1'b0;
                m_ptr   = (m_owner + 1) % N;
            end
        end
    endfunction

    // One cycle: drive inputs after the falling edge, check outputs, advance model
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] d, input logic rdy);
        logic [N-1:0] exp_grant;
        logic         exp_valid;
        logic         exp_data;
        @(negedge clk);
        rst       = r;
        req       = rq;
        data_in   = d;
        out_ready = rdy;
        #1;
        exp_grant = '0;
        if (m_owned) exp_grant[m_owner] = 1'b1;
        exp_valid = m_owned && rq[m_owner];
        exp_data  = exp_valid && d[m_owner];
        check("busy",      32'(busy),      32'(m_owned));
        check("grant",     32'(grant),     32'(exp_grant));
        check("sel",       32'(sel),       32'(m_sel));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_data",  32'(out_data),  32'(exp_data));
        if (capture_en && busy && !prev_busy) starts.push_back(int'(sel));
        prev_busy = busy;
        model_step(r, rq, rdy);
    endtask

    task automatic do_reset(input logic [N-1:0] rq);
        step(1'b1, rq, '0, 1'b0);
        step(1'b1, rq, '0, 1'b0);
    endtask

    initial begin
        int exp_seq[5];
        n_checks   = 0;
        n_pass     = 0;
        capture_en = 1'b0;
        prev_busy  = 1'b0;
        rst        = 1'b1;
        req        = '0;
        data_in    = '0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset with all requesting, then first grant goes to index 0
        do_reset(4'b1111);
        repeat (3) step(1'b0, 4'b1111, 4'b0101, 1'b1);

        // Single requester: burst of 3, one bubble, wrap back to index 2
        do_reset(4'b0000);
        repeat (10) step(1'b0, 4'b0100, 4'b0100, 1'b1);

        // Fairness: grant order 0,1,2,3,0
        do_reset(4'b0000);
        capture_en = 1'b1;
        repeat (22) step(1'b0, 4'b1111, 4'b1010, 1'b1);
        capture_en = 1'b0;
        exp_seq = '{0, 1, 2, 3, 0};
        check("fair_count", 32'(starts.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < starts.size()) check("fair_order", 32'(starts[i]), 32'(exp_seq[i]));
        end

        // Backpressure on index 1, then release
        do_reset(4'b0000);
        step(1'b0, 4'b0010, 4'b0010, 1'b0);
        repeat (5) step(1'b0, 4'b0010, 4'b0010, 1'b0);
        repeat (4) step(1'b0, 4'b0010, 4'b0010, 1'b1);

        // Early drop of index 3 after one transfer; next grant goes to index 0
        do_reset(4'b0000);
        step(1'b0, 4'b1000, 4'b1000, 1'b1);
        step(1'b0, 4'b1000, 4'b1000, 1'b1);
        step(1'b0, 4'b0011, 4'b0011, 1'b1);
        repeat (3) step(1'b0, 4'b0011, 4'b0011, 1'b1);

        // Reset during the second transfer of index 1
        do_reset(4'b0000);
        step(1'b0, 4'b0010, 4'b0010, 1'b1);
        step(1'b0, 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 4'b0010, 4'b0010, 1'b1);
        repeat (3) step(1'b0, 4'b0010, 4'b0010, 1'b1);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] rq;
            rq = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            step(($urandom_range(0, 60) == 0), rq, N'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rr_mux_arbiter

`default_nettype wire
